// File: rtl/fifo_rd_pkg.sv
// Shared types for the FIFO read-side controller.
//   buf_state_e : occupancy state of the 2-entry output skid buffer
//   RD_LATENCY  : cycles from r_en to valid FIFO d_out (the pending stage)
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_TWO   = 2'd2
  } buf_state_e;

  localparam int RD_LATENCY = 1;

endpackage

// File: rtl/fifo_rd_skid.sv
// Two-entry skid buffer feeding the valid/ready output stream.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   push, push_data : write one word (never asserted together with a full buffer)
//   pop             : head word consumed this cycle
//   buf_cnt         : number of words held (0..2)
//   head_valid      : buffer holds at least one word
//   head_data       : oldest word; held stable until popped
//
// state     | meaning
// ----------+------------------------------------------
// BUF_EMPTY | no word held, head_valid low
// BUF_ONE   | one word held in head
// BUF_TWO   | head plus one queued word in tail
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            buf_cnt,
  output logic                  head_valid,
  output logic [DATA_WIDTH-1:0] head_data
);

  buf_state_e            state;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= BUF_EMPTY;
      head_q <= '0;
      tail_q <= '0;
    end else begin
      case (state)
        BUF_EMPTY: begin
          if (push) begin
            head_q <= push_data;
            state  <= BUF_ONE;
          end
        end
        BUF_ONE: begin
          case ({push, pop})
            2'b10: begin
              tail_q <= push_data;
              state  <= BUF_TWO;
            end
            2'b01: state <= BUF_EMPTY;
            // Consumed and refilled in the same cycle: new word becomes head.
            2'b11: head_q <= push_data;
            default: ;
          endcase
        end
        BUF_TWO: begin
          // The read-issue rule keeps push low here.
          if (pop) begin
            head_q <= tail_q;
            state  <= BUF_ONE;
          end
        end
        default: state <= BUF_EMPTY;
      endcase
    end
  end

  always_comb begin
    buf_cnt = 2'd0;
    case (state)
      BUF_ONE: buf_cnt = 2'd1;
      BUF_TWO: buf_cnt = 2'd2;
      default: buf_cnt = 2'd0;
    endcase
  end

  assign head_valid = (state != BUF_EMPTY);
  assign head_data  = head_q;

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller for synchronous_fifo. Mirrors FIFO occupancy from the
// observed writes and its own reads, issues r_en, captures d_out one cycle
// later and presents words on a valid/ready stream via a 2-entry skid buffer.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   w_en           : FIFO write strobe (monitored only)
//   r_en           : FIFO read strobe
//   fifo_dout      : FIFO d_out, valid one cycle after r_en
//   m_valid/m_ready/m_data : output stream
//   count          : words resident in the FIFO, not yet read
//   full, empty    : count==DEPTH, count==0
//   ovf            : sticky write-while-full flag
// Build option: define OVF_FLAG_EN to build the ovf register; otherwise ovf is 0.
module fifo_read_ctrl
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       w_en,
  output logic                       r_en,
  input  logic [DATA_WIDTH-1:0]      fifo_dout,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_WIDTH-1:0]      m_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       ovf
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] count_q;
  logic             pending;
  logic [1:0]       buf_cnt;
  logic             pop;
  logic             wr_acc;
  logic [2:0]       in_flight;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign wr_acc = w_en && !full;
  assign pop    = m_valid && m_ready;

  // Words buffered or already requested, net of the one leaving this cycle.
  // pop implies buf_cnt>=1, so this never underflows.
  assign in_flight = {1'b0, buf_cnt} + {2'b00, pending} - {2'b00, pop};
  assign r_en      = !empty && (in_flight < 3'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      pending <= 1'b0;
    end else begin
      pending <= r_en;
      if (wr_acc && !r_en)
        count_q <= count_q + CNT_W'(1);
      else if (!wr_acc && r_en)
        count_q <= count_q - CNT_W'(1);
    end
  end

  assign count = count_q;

  fifo_rd_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk        (clk),
    .reset      (reset),
    .push       (pending),
    .push_data  (fifo_dout),
    .pop        (pop),
    .buf_cnt    (buf_cnt),
    .head_valid (m_valid),
    .head_data  (m_data)
  );

`ifdef OVF_FLAG_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (reset)
      ovf_q <= 1'b0;
    else if (w_en && full)
      ovf_q <= 1'b1;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
module tb_fifo_read_ctrl;

  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          w_en;
  logic [DW-1:0] w_data;
  logic          r_en;
  logic [DW-1:0] fifo_dout;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic [3:0]    count;
  logic          full;
  logic          empty;
  logic          ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int n_deliv  = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  logic          hold_prev = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic          exp_ovf;

  always #5 clk = ~clk;

  fifo_read_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .w_en      (w_en),
    .r_en      (r_en),
    .fifo_dout (fifo_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .ovf       (ovf)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural synchronous_fifo; accepted writes also feed the scoreboard.
  always @(posedge clk) begin
    logic acc;
    if (reset) begin
      fifo_q.delete();
      exp_q.delete();
      fifo_dout <= '0;
    end else begin
      acc = w_en && (fifo_q.size() < DEPTH);
      if (r_en) begin
        chk("read_while_fifo_nonempty", {31'd0, fifo_q.size() != 0}, 32'd1);
        if (fifo_q.size() != 0) fifo_dout <= fifo_q.pop_front();
      end
      if (acc) begin
        fifo_q.push_back(w_data);
        exp_q.push_back(w_data);
      end
    end
  end

  // Monitor: scoreboard pop on handshake, plus occupancy and hold checks.
  always @(negedge clk) begin
    if (reset) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", {31'd0, m_valid}, 32'd1);
        chk("hold_data", {24'd0, m_data}, {24'd0, hold_data});
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected_word: got %0h expected no word", m_data);
        end else begin
          chk("sb_data", {24'd0, m_data}, {24'd0, exp_q.pop_front()});
        end
        n_deliv++;
      end
      chk("count_vs_model", {28'd0, count}, fifo_q.size());
      chk("empty_vs_model", {31'd0, empty}, {31'd0, fifo_q.size() == 0});
      chk("full_vs_model", {31'd0, full}, {31'd0, fifo_q.size() == DEPTH});
      chk("buf_cnt_le2", {31'd0, dut.u_skid.buf_cnt <= 2'd2}, 32'd1);
      hold_prev = m_valid && !m_ready;
      hold_data = m_data;
    end
  end

  task automatic drain(input string nm, input int start, input int words);
    int cyc = 0;
    while ((exp_q.size() != 0 || m_valid || fifo_q.size() != 0) && cyc < 300) begin
      tick();
      cyc++;
    end
    @(negedge clk);
    chk({nm, "_drain_in_time"}, {31'd0, cyc < 300}, 32'd1);
    chk({nm, "_words_delivered"}, n_deliv - start, words);
    chk({nm, "_count_zero"}, {28'd0, count}, 32'd0);
  endtask

  initial begin
    int mark;
    logic [DW-1:0] t1_vec[3];
    t1_vec[0] = 8'hA1; t1_vec[1] = 8'hB2; t1_vec[2] = 8'hC3;
`ifdef OVF_FLAG_EN
    exp_ovf = 1'b1;
`else
    exp_ovf = 1'b0;
`endif

    reset = 1'b1; w_en = 1'b0; w_data = '0; m_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_r_en", {31'd0, r_en}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_data", {24'd0, m_data}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);

    // 1: three writes streamed straight through.
    mark = n_deliv;
    m_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      w_en = 1'b1; w_data = t1_vec[i];
      tick();
      w_en = 1'b0;
      @(negedge clk);
      chk("t1_r_en_after_write", {31'd0, r_en}, 32'd1);
      chk("t1_count_after_write", {28'd0, count}, 32'd1);
    end
    drain("t1", mark, 3);

    // 2: fill 8 with consumer stalled; two reads run ahead.
    mark = n_deliv;
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w_en = 1'b1; w_data = 8'h10 + 8'(i);
      tick();
    end
    w_en = 1'b0;
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t2_count", {28'd0, count}, 32'd6);
      chk("t2_m_valid", {31'd0, m_valid}, 32'd1);
      chk("t2_m_data_first", {24'd0, m_data}, 32'h10);
      chk("t2_r_en_stalled", {31'd0, r_en}, 32'd0);
      tick();
    end
    m_ready = 1'b1;
    drain("t2", mark, 8);

    // 3: full FIFO, dropped writes, simultaneous read at full.
    mark = n_deliv;
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      w_en = 1'b1; w_data = 8'h30 + 8'(i);
      tick();
    end
    w_en = 1'b0;
    @(negedge clk);
    chk("t3_count_full", {28'd0, count}, 32'd8);
    chk("t3_full", {31'd0, full}, 32'd1);
    chk("t3_ovf_before", {31'd0, ovf}, 32'd0);
    tick();
    w_en = 1'b1; w_data = 8'h55;
    tick();
    w_en = 1'b0;
    @(negedge clk);
    chk("t3_count_after_drop", {28'd0, count}, 32'd8);
    chk("t3_ovf", {31'd0, ovf}, {31'd0, exp_ovf});
    tick();
    m_ready = 1'b1; w_en = 1'b1; w_data = 8'h66;
    @(negedge clk);
    chk("t3_r_en_at_full", {31'd0, r_en}, 32'd1);
    tick();
    w_en = 1'b0;
    @(negedge clk);
    chk("t3_count_full_rw", {28'd0, count}, 32'd7);
    drain("t3", mark, 10);

    // 4: empty FIFO, consumer ready, no writes.
    m_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t4_r_en_idle", {31'd0, r_en}, 32'd0);
      chk("t4_m_valid_idle", {31'd0, m_valid}, 32'd0);
      tick();
    end

    // 5: reset with one word buffered and one read pending.
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w_en = 1'b1; w_data = 8'h91 + 8'(i);
      tick();
    end
    w_en = 1'b0;
    @(negedge clk);
    chk("t5_m_valid_pre", {31'd0, m_valid}, 32'd1);
    chk("t5_pending_pre", {31'd0, dut.pending}, 32'd1);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t5_m_valid_post", {31'd0, m_valid}, 32'd0);
    chk("t5_count_post", {28'd0, count}, 32'd0);
    chk("t5_r_en_post", {31'd0, r_en}, 32'd0);
    chk("t5_ovf_post", {31'd0, ovf}, 32'd0);
    mark = n_deliv;
    tick();
    w_en = 1'b1; w_data = 8'h7E;
    tick();
    w_en = 1'b0; m_ready = 1'b1;
    drain("t5", mark, 1);

    // 6: 200 writes against a randomly stalling consumer.
    mark = n_deliv;
    for (int i = 0; i < 200; ) begin
      m_ready = 1'($urandom_range(0, 1));
      if (fifo_q.size() < DEPTH && $urandom_range(0, 3) != 0) begin
        w_en = 1'b1; w_data = 8'(i) ^ 8'h5A;
        i++;
      end else begin
        w_en = 1'b0;
      end
      tick();
    end
    w_en = 1'b0; m_ready = 1'b1;
    drain("t6", mark, 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
